// File: rtl/press_event_gen.sv
// Synchronises and debounces N switch inputs, emitting a stable level
// plus single-cycle press, release and long-press pulses per channel.
module press_event_gen #(
  parameter int N          = 2,
  parameter int DEBOUNCE   = 16777216,
  parameter int LONG_PRESS = 50000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] sw,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] released,
  output logic [N-1:0] long,
  output logic         any_press
);

  localparam int MAXC = (DEBOUNCE > LONG_PRESS) ? DEBOUNCE : LONG_PRESS;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] DB  = CW'(DEBOUNCE);
  localparam logic [CW-1:0] LP  = CW'(LONG_PRESS);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG,
    RELEASE_WAIT
  } state_t;

  logic [N-1:0] s1, s2;
  logic [N-1:0] level_n, press_n, rel_n, long_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1        <= '0;
      s2        <= '0;
      level     <= '0;
      press     <= '0;
      released  <= '0;
      long      <= '0;
      any_press <= 1'b0;
    end else begin
      s1        <= sw;
      s2        <= s1;
      level     <= level_n;
      press     <= press_n;
      released  <= rel_n;
      long      <= long_n;
      any_press <= |press_n;
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_ch
    state_t        st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          p_n, r_n, l_n;

    always_ff @(posedge clk) begin
      if (rst) begin
        st  <= IDLE;
        cnt <= '0;
      end else begin
        st  <= st_n;
        cnt <= cnt_n;
      end
    end

    // cnt holds samples already seen, so cnt + 1 includes the current one
    always_comb begin
      st_n  = st;
      cnt_n = cnt;
      p_n   = 1'b0;
      r_n   = 1'b0;
      l_n   = 1'b0;
      unique case (st)
        IDLE: begin
          if (s2[i]) begin
            if (DB == ONE) begin
              st_n  = HELD;
              p_n   = 1'b1;
              cnt_n = '0;
            end else begin
              st_n  = PRESS_WAIT;
              cnt_n = ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (!s2[i]) begin
            st_n  = IDLE;
            cnt_n = '0;
          end else if (cnt + ONE == DB) begin
            st_n  = HELD;
            p_n   = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        HELD, LONG: begin
          if (!s2[i]) begin
            if (DB == ONE) begin
              st_n  = IDLE;
              r_n   = 1'b1;
              cnt_n = '0;
            end else begin
              st_n  = RELEASE_WAIT;
              cnt_n = ONE;
            end
          end else if (st == HELD) begin
            if (cnt + ONE == LP) begin
              st_n = LONG;
              l_n  = 1'b1;
            end else begin
              cnt_n = cnt + ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (s2[i]) begin
            st_n  = LONG;
            cnt_n = '0;
          end else if (cnt + ONE == DB) begin
            st_n  = IDLE;
            r_n   = 1'b1;
            cnt_n = '0;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
        default: begin
          st_n  = IDLE;
          cnt_n = '0;
        end
      endcase
    end

    assign level_n[i] = (st_n == HELD) || (st_n == LONG) ||
                        (st_n == RELEASE_WAIT);
    assign press_n[i] = p_n;
    assign rel_n[i]   = r_n;
    assign long_n[i]  = l_n;
  end

endmodule

// File: tb/tb_press_event_gen.sv
// Bench for press_event_gen: directed latency scenarios and random
// switch activity compared cycle by cycle against a run-length model.
module tb_press_event_gen;

  localparam int N  = 2;
  localparam int D  = 4;
  localparam int LP = 10;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] sw;
  logic [N-1:0] level, press, released, long;
  logic         any_press;

  int checks = 0;
  int errors = 0;

  // reference state: two-sample delay line, accepted level, run lengths
  logic [N-1:0] d1, d2;
  logic [N-1:0] m_level, m_press, m_rel, m_long;
  logic         m_any;
  int           run   [N];
  int           since [N];
  bit           lok   [N];

  always #5 clk = ~clk;

  press_event_gen #(
    .N(N),
    .DEBOUNCE(D),
    .LONG_PRESS(LP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .level(level),
    .press(press),
    .released(released),
    .long(long),
    .any_press(any_press)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] v;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    if (rst) begin
      d1      = '0;
      d2      = '0;
      m_level = '0;
      for (int c = 0; c < N; c++) begin
        run[c]   = 0;
        since[c] = 0;
        lok[c]   = 1'b0;
      end
    end else begin
      v  = d2;
      d2 = d1;
      d1 = sw;
      for (int c = 0; c < N; c++) begin
        if (m_level[c] && lok[c]) begin
          if (v[c]) begin
            since[c]++;
            if (since[c] == LP) begin
              m_long[c] = 1'b1;
              lok[c]    = 1'b0;
            end
          end else begin
            lok[c] = 1'b0;
          end
        end
        if (v[c] != m_level[c]) begin
          run[c]++;
          if (run[c] == D) begin
            m_level[c] = v[c];
            run[c]     = 0;
            if (v[c]) begin
              m_press[c] = 1'b1;
              lok[c]     = 1'b1;
              since[c]   = 0;
            end else begin
              m_rel[c] = 1'b1;
            end
          end
        end else begin
          run[c] = 0;
        end
      end
    end
    m_any = |m_press;
  endtask

  task automatic step(input logic [N-1:0] s, input logic r);
    sw  = s;
    rst = r;
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 32'(level), 32'(m_level));
    chk("press", 32'(press), 32'(m_press));
    chk("release", 32'(released), 32'(m_rel));
    chk("long", 32'(long), 32'(m_long));
    chk("any_press", 32'(any_press), 32'(m_any));
  endtask

  // steps with s held; reports on which step (1 = first) the pulse appears
  task automatic lat(input string tag, input logic [N-1:0] s,
                     input int ch, input int kind, input int exp);
    int  n;
    int  got;
    bit  hit;
    n   = 0;
    got = 0;
    while (got == 0 && n < 40) begin
      n++;
      step(s, 1'b0);
      case (kind)
        0:       hit = press[ch];
        1:       hit = released[ch];
        default: hit = long[ch];
      endcase
      if (hit) got = n;
    end
    chk(tag, 32'(got), 32'(exp));
  endtask

  initial begin
    sw  = '0;
    rst = 1'b1;
    d1  = '0;
    d2  = '0;
    m_level = '0;
    for (int c = 0; c < N; c++) begin
      run[c]   = 0;
      since[c] = 0;
      lok[c]   = 1'b0;
    end
    repeat (3) step(2'b00, 1'b1);
    chk("reset_level", 32'(level), 32'd0);
    chk("reset_press", 32'(press), 32'd0);
    repeat (4) step(2'b00, 1'b0);

    lat("clean_press", 2'b01, 0, 0, D + 2);
    repeat (3) step(2'b01, 1'b0);
    chk("clean_level", 32'(level[0]), 32'd1);
    lat("clean_release", 2'b00, 0, 1, D + 2);
    chk("clean_level_low", 32'(level[0]), 32'd0);
    repeat (4) step(2'b00, 1'b0);

    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b00, 1'b0);
    lat("bounce_press", 2'b01, 0, 0, D + 2);
    lat("bounce_release", 2'b00, 0, 1, D + 2);
    repeat (4) step(2'b00, 1'b0);

    lat("long_press", 2'b10, 1, 0, D + 2);
    lat("long_pulse", 2'b10, 1, 2, LP);
    repeat (3) step(2'b10, 1'b0);
    step(2'b00, 1'b0);
    step(2'b10, 1'b0);
    lat("release_bounce", 2'b00, 1, 1, D + 2);
    repeat (4) step(2'b00, 1'b0);

    lat("simul_press", 2'b11, 0, 0, D + 2);
    chk("simul_press_vec", 32'(press), 32'd3);
    chk("simul_any", 32'(any_press), 32'd1);
    step(2'b11, 1'b0);
    chk("simul_any_fall", 32'(any_press), 32'd0);
    lat("simul_release", 2'b00, 1, 1, D + 2);
    repeat (4) step(2'b00, 1'b0);

    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    chk("rst_mid_level", 32'(level), 32'd0);
    lat("rst_mid_press", 2'b01, 0, 0, D + 2);
    repeat (12) step(2'b01, 1'b0);
    step(2'b01, 1'b1);
    chk("rst_held_level", 32'(level), 32'd0);
    repeat (4) step(2'b00, 1'b0);

    for (int k = 0; k < 3000; k++) begin
      logic [N-1:0] s;
      s = sw;
      for (int c = 0; c < N; c++)
        if ($urandom_range(7) == 0) s[c] = ~s[c];
      step(s, ($urandom_range(299) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
